// File: rtl/fir_seq_pkg.sv
// Shared types and default constants for the per-band FIR queue sequencer.
package fir_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned TAPS_DEF   = 1021;
  localparam int unsigned DECIM_DEF  = 2;
  localparam int unsigned RD_LAT     = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SWEEP,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/queue_wr_tracker.sv
// Write-side bookkeeping: decimation, write pointer, fill level and sweep trigger.
module queue_wr_tracker
  import fir_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned DECIM  = DECIM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_vld_i,
  output logic              accept_o,
  output logic              trigger_o,
  output logic [ADDR_W-1:0] new_ptr_o,
  output logic [ADDR_W-1:0] oldest_o,
  output logic              sequencing_o
);

  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [ADDR_W-1:0] new_ptr_q, new_ptr_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              seq_q;
  logic              dec_last;

  assign dec_last = (dec_cnt_q == DEC_W'(DECIM - 1));
  // Gating with rst_n keeps the combinational write strobe quiet during reset.
  assign accept_o  = smpl_vld_i & rst_n & dec_last;
  assign trigger_o = accept_o & (fill_cnt_q >= ADDR_W'(TAPS - 1));

  always_comb begin
    dec_cnt_d  = dec_cnt_q;
    new_ptr_d  = new_ptr_q;
    fill_cnt_d = fill_cnt_q;
    if (smpl_vld_i) begin
      dec_cnt_d = dec_last ? '0 : dec_cnt_q + 1'b1;
    end
    if (accept_o) begin
      new_ptr_d = new_ptr_q + 1'b1;
      if (fill_cnt_q != ADDR_W'(TAPS)) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q  <= '0;
      new_ptr_q  <= '0;
      fill_cnt_q <= '0;
      seq_q      <= 1'b0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      new_ptr_q  <= new_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      seq_q      <= (fill_cnt_d == ADDR_W'(TAPS));
    end
  end

  assign new_ptr_o    = new_ptr_q;
  // The sample being written now is the newest, so the window starts TAPS-1 behind it.
  assign oldest_o     = new_ptr_q + ADDR_W'(1) - ADDR_W'(TAPS);
  assign sequencing_o = seq_q;

endmodule

// File: rtl/fir_queue_sequencer.sv
// Per-band controller for the circular sample queue and its FIR MAC engine.
module fir_queue_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned DECIM  = DECIM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_vld,
  input  logic              clr_ovr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              result_vld,
  output logic              sequencing,
  output logic              busy,
  output logic              overrun
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] coeff_q, coeff_d;
  logic [ADDR_W-1:0] oldest_q, oldest_d;
  logic [ADDR_W-1:0] oldest_w;
  logic              overrun_q, overrun_d;
  logic              accept, trigger;
  logic [RD_LAT-1:0] mac_pipe_q;

  queue_wr_tracker #(
    .ADDR_W (ADDR_W),
    .TAPS   (TAPS),
    .DECIM  (DECIM)
  ) u_wr_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .smpl_vld_i   (smpl_vld),
    .accept_o     (accept),
    .trigger_o    (trigger),
    .new_ptr_o    (waddr),
    .oldest_o     (oldest_w),
    .sequencing_o (sequencing)
  );

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    coeff_d    = coeff_q;
    oldest_d   = oldest_q;
    overrun_d  = overrun_q;
    mac_clr    = 1'b0;
    result_vld = 1'b0;

    if (clr_ovr) overrun_d = 1'b0;
    if (trigger && (state_q != IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = CLR;
          oldest_d = oldest_w;
        end
      end
      CLR: begin
        mac_clr = 1'b1;
        raddr_d = oldest_q;
        coeff_d = '0;
        state_d = SWEEP;
      end
      SWEEP: begin
        // coeff_addr doubles as the issue counter; the last issue leaves both addresses parked.
        if (coeff_q == ADDR_W'(TAPS - 1)) begin
          state_d = DRAIN;
        end else begin
          raddr_d = raddr_q + 1'b1;
          coeff_d = coeff_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        result_vld = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      raddr_q    <= '0;
      coeff_q    <= '0;
      oldest_q   <= '0;
      overrun_q  <= 1'b0;
      mac_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      coeff_q    <= coeff_d;
      oldest_q   <= oldest_d;
      overrun_q  <= overrun_d;
      // Issue-valid delayed by the RAM/ROM read latency.
      mac_pipe_q <= RD_LAT'({mac_pipe_q, (state_q == SWEEP)});
    end
  end

  assign we         = accept;
  assign raddr      = raddr_q;
  assign coeff_addr = coeff_q;
  assign mac_en     = mac_pipe_q[RD_LAT-1];
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_queue_sequencer.sv
// Directed bench: low-band (DECIM=2) and high-band (DECIM=1) instances side by side.
module tb_fir_queue_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic smpl2 = 1'b0, clr2 = 1'b0;
  logic we2, mac_clr2, mac_en2, res2, seq2, busy2, ovr2;
  logic [9:0] waddr2, raddr2, coeff2;

  logic smpl1 = 1'b0, clr1 = 1'b0;
  logic we1, mac_clr1, mac_en1, res1, seq1, busy1, ovr1;
  logic [9:0] waddr1, raddr1, coeff1;

  int checks = 0;
  int errors = 0;

  fir_queue_sequencer #(.ADDR_W(10), .TAPS(1021), .DECIM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl2), .clr_ovr(clr2),
    .we(we2), .waddr(waddr2), .raddr(raddr2), .coeff_addr(coeff2),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .result_vld(res2),
    .sequencing(seq2), .busy(busy2), .overrun(ovr2)
  );

  fir_queue_sequencer #(.ADDR_W(10), .TAPS(1021), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl1), .clr_ovr(clr1),
    .we(we1), .waddr(waddr1), .raddr(raddr1), .coeff_addr(coeff1),
    .mac_clr(mac_clr1), .mac_en(mac_en1), .result_vld(res1),
    .sequencing(seq1), .busy(busy1), .overrun(ovr1)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    smpl1 = 1'b0; smpl2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] v2, v1;
    rst_n = 1'b0;
    smpl1 = 1'b1;
    @(negedge clk);
    checks++;
    if (we1 !== 1'b0) begin errors++; $display("FAIL reset_we_gated got %0b exp 0", we1); end
    smpl1 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v2 = {we2, waddr2, raddr2, coeff2, mac_clr2, mac_en2, res2, seq2, busy2, ovr2};
      v1 = {we1, waddr1, raddr1, coeff1, mac_clr1, mac_en1, res1, seq1, busy1, ovr1};
      checks++;
      if (v2 !== '0) begin errors++; $display("FAIL idle_outs2 cyc=%0d got %h exp 0", i, v2); end
      checks++;
      if (v1 !== '0) begin errors++; $display("FAIL idle_outs1 cyc=%0d got %h exp 0", i, v1); end
    end
    @(posedge clk); #1 smpl1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (waddr1 !== 10'd3) begin errors++; $display("FAIL pre_async_waddr got %0d exp 3", waddr1); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (waddr1 !== 10'd0) begin errors++; $display("FAIL async_waddr got %0d exp 0", waddr1); end
    checks++;
    if (we1 !== 1'b0) begin errors++; $display("FAIL async_we got %0b exp 0", we1); end
    smpl1 = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_decim();
    for (int p = 1; p <= 4; p++) begin
      @(posedge clk); #1 smpl2 = 1'b1;
      @(negedge clk);
      checks++;
      if (we2 !== (p % 2 == 0)) begin errors++; $display("FAIL decim_we p=%0d got %0b exp %0b", p, we2, (p % 2 == 0)); end
      checks++;
      if (waddr2 !== 10'((p - 1) / 2)) begin errors++; $display("FAIL decim_waddr p=%0d got %0d exp %0d", p, waddr2, (p - 1) / 2); end
      @(posedge clk); #1 smpl2 = 1'b0;
      repeat (8) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (waddr2 !== 10'd2) begin errors++; $display("FAIL decim_final_waddr got %0d exp 2", waddr2); end
    checks++;
    if (seq2 !== 1'b0) begin errors++; $display("FAIL decim_seq got %0b exp 0", seq2); end
  endtask

  task automatic test_fill_sweep();
    do_reset();
    for (int s = 1; s <= 2042; s++) begin
      @(posedge clk); #1 smpl2 = 1'b1;
      @(negedge clk);
      checks++;
      if (we2 !== (s % 2 == 0)) begin errors++; $display("FAIL fill_we s=%0d got %0b exp %0b", s, we2, (s % 2 == 0)); end
      if (s == 2042) begin
        checks++;
        if (waddr2 !== 10'd1020) begin errors++; $display("FAIL fill_last_waddr got %0d exp 1020", waddr2); end
        checks++;
        if (seq2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL fill_trig_state got seq=%0b busy=%0b exp 0 0", seq2, busy2); end
      end
    end
    for (int c = 1; c <= 1025; c++) begin
      @(posedge clk); #1 smpl2 = 1'b0;
      @(negedge clk);
      checks++;
      if (mac_clr2 !== (c == 1)) begin errors++; $display("FAIL sw_mac_clr c=%0d got %0b exp %0b", c, mac_clr2, (c == 1)); end
      checks++;
      if (mac_en2 !== (c >= 3 && c <= 1023)) begin errors++; $display("FAIL sw_mac_en c=%0d got %0b", c, mac_en2); end
      checks++;
      if (res2 !== (c == 1024)) begin errors++; $display("FAIL sw_result_vld c=%0d got %0b", c, res2); end
      checks++;
      if (busy2 !== (c <= 1024) || seq2 !== 1'b1) begin errors++; $display("FAIL sw_busy_seq c=%0d got busy=%0b seq=%0b", c, busy2, seq2); end
      if (c >= 2) begin
        checks++;
        if (raddr2 !== 10'((c <= 1022) ? c - 2 : 1020)) begin errors++; $display("FAIL sw_raddr c=%0d got %0d exp %0d", c, raddr2, (c <= 1022) ? c - 2 : 1020); end
        checks++;
        if (coeff2 !== 10'((c <= 1022) ? c - 2 : 1020)) begin errors++; $display("FAIL sw_coeff c=%0d got %0d exp %0d", c, coeff2, (c <= 1022) ? c - 2 : 1020); end
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    for (int a = 1; a <= 8; a++) begin
      repeat (2) begin
        @(posedge clk); #1 smpl2 = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (waddr2 !== 10'(1020 + a)) begin errors++; $display("FAIL wrap_step_waddr a=%0d got %0d exp %0d", a, waddr2, 1020 + a); end
      @(posedge clk); #1 smpl2 = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy2 && n < 1100);
      checks++;
      if (n != 1025) begin errors++; $display("FAIL wrap_step_len a=%0d got %0d exp 1025", a, n); end
    end
    @(posedge clk); #1 smpl2 = 1'b1;
    @(negedge clk);
    checks++;
    if (we2 !== 1'b0) begin errors++; $display("FAIL wrap_odd_we got %0b exp 0", we2); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (we2 !== 1'b1 || waddr2 !== 10'd5) begin errors++; $display("FAIL wrap_last_write got we=%0b waddr=%0d exp 1 5", we2, waddr2); end
    for (int c = 1; c <= 1025; c++) begin
      @(posedge clk); #1 smpl2 = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 1022) begin
        checks++;
        if (raddr2 !== 10'((9 + c - 2) % 1024)) begin errors++; $display("FAIL wrap_raddr c=%0d got %0d exp %0d", c, raddr2, (9 + c - 2) % 1024); end
        checks++;
        if (coeff2 !== 10'(c - 2)) begin errors++; $display("FAIL wrap_coeff c=%0d got %0d exp %0d", c, coeff2, c - 2); end
      end
      checks++;
      if (res2 !== (c == 1024)) begin errors++; $display("FAIL wrap_result_vld c=%0d got %0b", c, res2); end
    end
    checks++;
    if (ovr2 !== 1'b0) begin errors++; $display("FAIL wrap_overrun got %0b exp 0", ovr2); end
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    for (int s = 1; s <= 1021; s++) begin
      @(posedge clk); #1 smpl1 = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (we1 !== 1'b1 || waddr1 !== 10'd1020 || busy1 !== 1'b0) begin errors++; $display("FAIL ovr_trig got we=%0b waddr=%0d busy=%0b exp 1 1020 0", we1, waddr1, busy1); end
    for (int c = 1; c <= 1025; c++) begin
      @(posedge clk); #1 smpl1 = (c == 100);
      @(negedge clk);
      checks++;
      if (we1 !== (c == 100)) begin errors++; $display("FAIL ovr_we c=%0d got %0b", c, we1); end
      if (c == 100) begin
        checks++;
        if (waddr1 !== 10'd1021 || busy1 !== 1'b1) begin errors++; $display("FAIL ovr_drop_write got waddr=%0d busy=%0b exp 1021 1", waddr1, busy1); end
      end
      checks++;
      if (ovr1 !== (c >= 101)) begin errors++; $display("FAIL ovr_flag c=%0d got %0b exp %0b", c, ovr1, (c >= 101)); end
      checks++;
      if (mac_clr1 !== (c == 1) || mac_en1 !== (c >= 3 && c <= 1023)) begin errors++; $display("FAIL ovr_mac c=%0d got clr=%0b en=%0b", c, mac_clr1, mac_en1); end
      checks++;
      if (res1 !== (c == 1024) || busy1 !== (c <= 1024)) begin errors++; $display("FAIL ovr_done c=%0d got res=%0b busy=%0b", c, res1, busy1); end
      if (c >= 2 && c <= 1022) begin
        checks++;
        if (raddr1 !== 10'(c - 2)) begin errors++; $display("FAIL ovr_raddr c=%0d got %0d exp %0d", c, raddr1, c - 2); end
      end
    end
    @(posedge clk); #1 clr1 = 1'b1;
    @(posedge clk); #1 clr1 = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr1 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b exp 0", ovr1); end
    @(posedge clk); #1 smpl1 = 1'b1;
    @(posedge clk); #1 smpl1 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1 || ovr1 !== 1'b0) begin errors++; $display("FAIL ovr_sweep2 got busy=%0b ovr=%0b exp 1 0", busy1, ovr1); end
    repeat (4) @(posedge clk);
    #1 smpl1 = 1'b1; clr1 = 1'b1;
    @(posedge clk); #1 smpl1 = 1'b0; clr1 = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr1 !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %0b exp 1", ovr1); end
    n = 0;
    while (busy1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL ovr_sweep2_end got busy=%0b exp 0", busy1); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int s = 1; s <= 2042; s++) begin
      @(posedge clk); #1 smpl2 = 1'b1;
      @(negedge clk);
    end
    for (int c = 1; c <= 500; c++) begin
      @(posedge clk); #1 smpl2 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (mac_en2 !== 1'b1 || busy2 !== 1'b1 || seq2 !== 1'b1 || raddr2 !== 10'd498) begin
      errors++; $display("FAIL mid_pre got en=%0b busy=%0b seq=%0b raddr=%0d exp 1 1 1 498", mac_en2, busy2, seq2, raddr2);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mac_en2 !== 1'b0 || busy2 !== 1'b0 || seq2 !== 1'b0 || raddr2 !== 10'd0) begin
      errors++; $display("FAIL mid_async got en=%0b busy=%0b seq=%0b raddr=%0d exp 0 0 0 0", mac_en2, busy2, seq2, raddr2);
    end
    #1 rst_n = 1'b1;
    for (int s = 1; s <= 2042; s++) begin
      @(posedge clk); #1 smpl2 = 1'b1;
      @(negedge clk);
      checks++;
      if (busy2 !== 1'b0) begin errors++; $display("FAIL mid_refill_busy s=%0d got %0b exp 0", s, busy2); end
      if (s == 2041) begin
        checks++;
        if (seq2 !== 1'b0) begin errors++; $display("FAIL mid_refill_seq got %0b exp 0", seq2); end
      end
    end
    checks++;
    if (we2 !== 1'b1 || waddr2 !== 10'd1020) begin errors++; $display("FAIL mid_refill_last got we=%0b waddr=%0d exp 1 1020", we2, waddr2); end
    @(posedge clk); #1 smpl2 = 1'b0;
    @(negedge clk);
    checks++;
    if (mac_clr2 !== 1'b1 || busy2 !== 1'b1 || seq2 !== 1'b1) begin errors++; $display("FAIL mid_restart got clr=%0b busy=%0b seq=%0b exp 1 1 1", mac_clr2, busy2, seq2); end
    n = 0;
    while (busy2 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL mid_sweep_end got busy=%0b exp 0", busy2); end
  endtask

  initial begin
    test_reset();
    test_decim();
    test_fill_sweep();
    test_wrap();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_queue_sequencer.md
Name: fir_queue_sequencer

Overview:
Controller that sequences one band's circular sample queue (1024x16 dual-port RAM) and its FIR multiply-accumulate engine.
- Accepts codec sample strobes, decimates them per band, generates RAM write strobes and addresses, and tracks queue fill.
- On each accepted sample once the queue is full, sweeps read addresses over the most recent TAPS samples with matching coefficient-ROM addresses and MAC control.
- One instance per band (low band DECIM=2, high band DECIM=1), placed between the codec interface and the per-band RAM/ROM/MAC datapath.

Parameters:
ADDR_W, 10, queue/coefficient address width; queue depth is 2**ADDR_W.
TAPS, 1021, samples per convolution; legal range 2 to 2**ADDR_W-1.
DECIM, 2, accept one of every DECIM sample strobes (legal >=1).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
smpl_vld  in  1  one-cycle strobe per codec sample; the sample data goes straight to the RAM.
clr_ovr  in  1  clears the overrun flag.
we  out  1  RAM write enable.
waddr  out  ADDR_W  RAM write address.
raddr  out  ADDR_W  RAM read address.
coeff_addr  out  ADDR_W  coefficient ROM address.
mac_clr  out  1  clear the accumulator.
mac_en  out  1  accumulate the product of RAM and ROM data.
result_vld  out  1  one-cycle pulse when the accumulator holds the final sum.
sequencing  out  1  queue holds at least TAPS samples.
busy  out  1  FSM is not in IDLE.
overrun  out  1  sticky: a sweep trigger was dropped.

Behaviour:
- Reset: all registered state is 0, FSM is IDLE, every output is 0. The async reset is honoured mid-sweep: the sweep aborts, fill is lost, and sequencing drops.
- Decimation:
  - dec_cnt counts 0..DECIM-1 on each smpl_vld and wraps.
  - accept = smpl_vld & (dec_cnt==DECIM-1).
  - DECIM=1 accepts every strobe.
- Write path:
  - we = accept (combinational, same cycle as smpl_vld, 0 while in reset).
  - waddr = new_ptr register; new_ptr increments on accept, mod 2**ADDR_W.
  - Writes are never blocked, including during a sweep.
- Fill:
  - fill_cnt increments on accept and saturates at TAPS.
  - sequencing = (fill_cnt==TAPS), registered.
- Trigger = accept while the post-write fill equals TAPS (i.e. fill_cnt>=TAPS-1).
  - On trigger in IDLE, capture oldest = (new_ptr+1-TAPS) mod 2**ADDR_W.
  - The newest sample is the one being written this cycle.
- FSM (T = trigger cycle):
  - IDLE: on trigger, go to CLR.
  - CLR (T+1): mac_clr=1; raddr <= oldest, coeff_addr <= 0.
  - SWEEP (T+2 .. T+TAPS+1): issues TAPS reads; raddr and coeff_addr present issue k (k=0..TAPS-1) = oldest+k (wrapping) and k.
  - DRAIN (T+TAPS+2): 1 cycle covering RAM/ROM read latency.
  - DONE (T+TAPS+3): result_vld=1, then IDLE.
- mac_en = issue-valid delayed 1 cycle. It is high exactly TAPS consecutive cycles, T+3..T+TAPS+2.
- mac_clr and mac_en are never high in the same cycle.
- raddr and coeff_addr hold their last value outside SWEEP.
- Concurrent writes: the snapshot makes the sweep immune to them. Up to 2**ADDR_W-TAPS (3 by default) accepts during a sweep are safe.
- Overrun:
  - A trigger while busy is dropped: no restart, the write still occurs, overrun <= 1.
  - clr_ovr clears overrun; if set and clear coincide, set wins.
- Wrap-around: all pointer arithmetic is unsigned mod 2**ADDR_W. A sweep crossing address 2**ADDR_W-1 continues at 0.

Decomposition:
- Shared package fir_seq_pkg holds:
  - the state enum (IDLE, CLR, SWEEP, DRAIN, DONE);
  - default ADDR_W/TAPS/DECIM constants;
  - a RD_LAT=1 constant.
- One natural sub-module, queue_wr_tracker, holds dec_cnt, new_ptr, fill_cnt, accept/trigger and sequencing.
- The FSM, sweep counters and MAC control stay in the top.

Test Plan:
1. Reset then idle, with smpl_vld held 0 -> all outputs 0, busy=0, for 20 cycles; rst_n asserted asynchronously mid-clock clears outputs immediately.
2. DECIM=2, four smpl_vld pulses 10 cycles apart -> we only on pulses 2 and 4, with waddr 0 then 1; no sequencing.
3. Defaults, 2042 strobes -> sequencing=1 after the write at waddr 1020; then:
   - mac_clr at T+1;
   - raddr 0..1020 and coeff_addr 0..1020 during SWEEP;
   - mac_en high 1021 cycles;
   - result_vld at T+1024.
4. Wrap: continue to 1030 accepted writes, last waddr 1029 mod 1024 = 5 -> sweep raddr 9..1023 then 0..5 (1021 reads), coeff_addr 0..1020.
5. Overrun: DECIM=1, accept a strobe 100 cycles into a sweep -> we=1, no restart, sweep finishes normally, overrun=1; clr_ovr pulse -> overrun=0; set and clear in the same cycle -> overrun stays 1.
6. Reset mid-SWEEP (cycle T+500) -> mac_en, busy and sequencing drop to 0; after release, no sweep until TAPS new accepts (2042 strobes).
